// File: rtl/time_set_ctrl.sv
// Time/alarm setting controller: captures a target's BCD time, steps
// fields with auto-repeat, commits with a one-hot load or abandons on idle.
module time_set_ctrl #(
    parameter int N_TGT      = 2,
    parameter int TIMEOUT_TK = 10000,
    parameter int RPT_DLY_TK = 500,
    parameter int RPT_PER_TK = 100,
    localparam int TW = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             set_p,
    input  logic             sel_p,
    input  logic             inc_p,
    input  logic             dec_p,
    input  logic             inc_hold,
    input  logic             dec_hold,
    input  logic [TW-1:0]    tgt_req,
    input  logic [8*N_TGT-1:0] cur_hh,
    input  logic [8*N_TGT-1:0] cur_mm,
    input  logic [8*N_TGT-1:0] cur_ss,
    output logic             set_en,
    output logic [N_TGT-1:0] set_load,
    output logic             set_abort,
    output logic [7:0]       set_hh,
    output logic [7:0]       set_mm,
    output logic [7:0]       set_ss,
    output logic [1:0]       blink_sel
);

    // State codes double as the blink_sel encoding.
    localparam logic [1:0] S_HH = 2'b00;
    localparam logic [1:0] S_MM = 2'b01;
    localparam logic [1:0] S_SS = 2'b10;
    localparam logic [1:0] IDLE = 2'b11;

    localparam int RMAX = (RPT_DLY_TK > RPT_PER_TK) ?
                          RPT_DLY_TK : RPT_PER_TK;
    localparam int RW  = $clog2(RMAX + 1);
    localparam int TOW = $clog2(TIMEOUT_TK + 1);

    localparam logic [RW:0]  DLY_C = (RW+1)'(RPT_DLY_TK);
    localparam logic [RW:0]  PER_C = (RW+1)'(RPT_PER_TK);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_TK - 1);
    localparam logic [TW:0]  NT_C  = (TW+1)'(N_TGT);

    function automatic logic bcd_ok(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic [7:0] bcd_step(
        input logic [7:0] v,
        input logic [7:0] lim,
        input logic       up
    );
        logic [7:0] r;
        if (up) begin
            if (v == lim)
                r = 8'h00;
            else if (v[3:0] == 4'd9)
                r = {v[7:4] + 4'd1, 4'd0};
            else
                r = v + 8'd1;
        end else begin
            if (v == 8'h00)
                r = lim;
            else if (v[3:0] == 4'd0)
                r = {v[7:4] - 4'd1, 4'd9};
            else
                r = v - 8'd1;
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tgt_q, tgt_d;
    logic [7:0]       hh_q, hh_d;
    logic [7:0]       mm_q, mm_d;
    logic [7:0]       ss_q, ss_d;
    logic [N_TGT-1:0] load_q, load_d;
    logic             abort_q, abort_d;
    logic             en_q, en_d;
    logic [RW-1:0]    ic_q, ic_d;
    logic [RW-1:0]    dc_q, dc_d;
    logic             ir_q, ir_d;
    logic             dr_q, dr_d;
    logic [TOW-1:0]   to_q, to_d;

    logic        edit;
    logic        inc_ev;
    logic        dec_ev;
    logic        expire;
    logic        up;
    logic        dn;
    logic [RW:0] inc_nx;
    logic [RW:0] dec_nx;
    logic [7:0]  cur_h;
    logic [7:0]  cur_m;
    logic [7:0]  cur_s;
    logic        tgt_ok;

    assign edit   = (state_q != IDLE);
    assign up     = inc_p | inc_ev;
    assign dn     = dec_p | dec_ev;
    assign tgt_ok = ({1'b0, tgt_req} < NT_C);

    always_comb begin
        cur_h = 8'h00;
        cur_m = 8'h00;
        cur_s = 8'h00;
        for (int k = 0; k < N_TGT; k++) begin
            if (tgt_req == TW'(k)) begin
                cur_h = cur_hh[8*k +: 8];
                cur_m = cur_mm[8*k +: 8];
                cur_s = cur_ss[8*k +: 8];
            end
        end
    end

    // Hold counters: first event after the delay, then every period.
    always_comb begin
        inc_nx = {1'b0, ic_q} + 1'b1;
        ic_d   = ic_q;
        ir_d   = ir_q;
        inc_ev = 1'b0;
        if (!edit || set_p || !inc_hold || inc_p) begin
            ic_d = '0;
            ir_d = 1'b0;
        end else if (tick) begin
            if (inc_nx >= (ir_q ? PER_C : DLY_C)) begin
                inc_ev = 1'b1;
                ic_d   = '0;
                ir_d   = 1'b1;
            end else begin
                ic_d = inc_nx[RW-1:0];
            end
        end
    end

    always_comb begin
        dec_nx = {1'b0, dc_q} + 1'b1;
        dc_d   = dc_q;
        dr_d   = dr_q;
        dec_ev = 1'b0;
        if (!edit || set_p || !dec_hold || dec_p) begin
            dc_d = '0;
            dr_d = 1'b0;
        end else if (tick) begin
            if (dec_nx >= (dr_q ? PER_C : DLY_C)) begin
                dec_ev = 1'b1;
                dc_d   = '0;
                dr_d   = 1'b1;
            end else begin
                dc_d = dec_nx[RW-1:0];
            end
        end
    end

    always_comb begin
        to_d   = to_q;
        expire = 1'b0;
        if (!edit || set_p || sel_p || inc_p || dec_p ||
            inc_ev || dec_ev) begin
            to_d = '0;
        end else if (tick) begin
            if (to_q >= TO_LAST)
                expire = 1'b1;
            else
                to_d = to_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        load_d  = '0;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (set_p && tgt_ok) begin
                    tgt_d   = tgt_req;
                    hh_d    = bcd_ok(cur_h, 8'h23) ? cur_h : 8'h00;
                    mm_d    = bcd_ok(cur_m, 8'h59) ? cur_m : 8'h00;
                    ss_d    = bcd_ok(cur_s, 8'h59) ? cur_s : 8'h00;
                    state_d = S_HH;
                end
            end
            S_HH, S_MM, S_SS: begin
                if (set_p) begin
                    state_d = IDLE;
                    for (int k = 0; k < N_TGT; k++)
                        load_d[k] = (tgt_q == TW'(k));
                end else if (sel_p) begin
                    state_d = (state_q == S_SS) ? S_HH :
                              state_q + 2'd1;
                end else if (expire) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (up ^ dn) begin
                    unique case (state_q)
                        S_HH:    hh_d = bcd_step(hh_q, 8'h23, up);
                        S_MM:    mm_d = bcd_step(mm_q, 8'h59, up);
                        default: ss_d = bcd_step(ss_q, 8'h59, up);
                    endcase
                end
            end
        endcase
        en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            hh_q    <= 8'h00;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            load_q  <= '0;
            abort_q <= 1'b0;
            en_q    <= 1'b0;
            ic_q    <= '0;
            dc_q    <= '0;
            ir_q    <= 1'b0;
            dr_q    <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            load_q  <= load_d;
            abort_q <= abort_d;
            en_q    <= en_d;
            ic_q    <= ic_d;
            dc_q    <= dc_d;
            ir_q    <= ir_d;
            dr_q    <= dr_d;
            to_q    <= to_d;
        end
    end

    assign set_en    = en_q;
    assign set_load  = load_q;
    assign set_abort = abort_q;
    assign set_hh    = hh_q;
    assign set_mm    = mm_q;
    assign set_ss    = ss_q;
    assign blink_sel = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with shortened timing parameters.
module tb_time_set_ctrl;

    localparam int N   = 3;
    localparam int TO  = 50;
    localparam int DLY = 5;
    localparam int PER = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          set_p, sel_p, inc_p, dec_p;
    logic          inc_hold, dec_hold;
    logic [1:0]    tgt_req;
    logic [8*N-1:0] cur_hh, cur_mm, cur_ss;
    logic          set_en;
    logic [N-1:0]  set_load;
    logic          set_abort;
    logic [7:0]    set_hh, set_mm, set_ss;
    logic [1:0]    blink_sel;

    int n_chk  = 0;
    int n_pass = 0;

    time_set_ctrl #(
        .N_TGT(N), .TIMEOUT_TK(TO),
        .RPT_DLY_TK(DLY), .RPT_PER_TK(PER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .set_p(set_p), .sel_p(sel_p),
        .inc_p(inc_p), .dec_p(dec_p),
        .inc_hold(inc_hold), .dec_hold(dec_hold),
        .tgt_req(tgt_req),
        .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
        .set_en(set_en), .set_load(set_load),
        .set_abort(set_abort),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .blink_sel(blink_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // k = {set, sel, inc, dec}
    task automatic keys(input logic [3:0] k);
        {set_p, sel_p, inc_p, dec_p} = k;
        cyc();
        {set_p, sel_p, inc_p, dec_p} = 4'b0000;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tick     = 1'b0;
        {set_p, sel_p, inc_p, dec_p} = 4'b0000;
        inc_hold = 1'b0;
        dec_hold = 1'b0;
        tgt_req  = 2'd0;
        cur_hh   = 24'h00_12_00;
        cur_mm   = 24'h00_34_00;
        cur_ss   = 24'h00_56_00;
        cyc();
        cyc();
        chk("rst_en", set_en, 0);
        chk("rst_load", set_load, 0);
        chk("rst_abort", set_abort, 0);
        chk("rst_hms", {set_hh, set_mm, set_ss}, 0);
        chk("rst_blink", blink_sel, 2'b11);
        rst_n = 1'b1;
        cyc();

        // Enter target 1, wrap hours through 23 -> 00, commit
        tgt_req = 2'd1;
        keys(4'b1000);
        chk("t1_en", set_en, 1);
        chk("t1_hh", set_hh, 8'h12);
        chk("t1_blink", blink_sel, 2'b00);
        for (int i = 0; i < 12; i++) keys(4'b0010);
        chk("t1_wrap", set_hh, 8'h00);
        keys(4'b1000);
        chk("t1_load", set_load, 3'b010);
        chk("t1_en0", set_en, 0);
        chk("t1_hms", {set_hh, set_mm, set_ss}, 24'h003456);
        cyc();
        chk("t1_load1", set_load, 0);
        chk("t1_hold", {set_hh, set_mm, set_ss}, 24'h003456);

        // Minutes borrow, cancel, select-beats-step
        tgt_req = 2'd0;
        keys(4'b1000);
        chk("t2_hms", {set_hh, set_mm, set_ss}, 0);
        keys(4'b0100);
        chk("t2_blink", blink_sel, 2'b01);
        keys(4'b0001);
        chk("t2_mm59", set_mm, 8'h59);
        chk("t2_hh", set_hh, 8'h00);
        keys(4'b0011);
        chk("t2_cancel", set_mm, 8'h59);
        keys(4'b0110);
        chk("t2_sel", blink_sel, 2'b10);
        chk("t2_mmkeep", set_mm, 8'h59);
        chk("t2_ssnostep", set_ss, 8'h00);

        // Auto-repeat from ss=58: four events
        keys(4'b0001);
        keys(4'b0001);
        chk("t3_ss58", set_ss, 8'h58);
        inc_hold = 1'b1;
        ticks(DLY + 3 * PER);
        inc_hold = 1'b0;
        cyc();
        chk("t3_rpt", set_ss, 8'h02);
        chk("t3_en", set_en, 1);
        keys(4'b1000);
        chk("t3_load", set_load, 3'b001);

        // Digit carry and borrow across 09/10
        cur_hh = 24'h00_12_09;
        cur_mm = 24'h00_34_10;
        keys(4'b1000);
        keys(4'b0010);
        chk("cy_hh", set_hh, 8'h10);
        keys(4'b0100);
        keys(4'b0001);
        chk("cy_mm", set_mm, 8'h09);
        keys(4'b1000);

        // Out-of-range target is ignored
        tgt_req = 2'd3;
        keys(4'b1000);
        chk("tg_ign", set_en, 0);
        chk("tg_blink", blink_sel, 2'b11);

        // Timeout abandon
        tgt_req = 2'd0;
        keys(4'b1000);
        ticks(TO - 1);
        chk("to_pre", set_en, 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("to_abort", set_abort, 1);
        chk("to_en", set_en, 0);
        chk("to_load", set_load, 0);
        cyc();
        chk("to_abort1", set_abort, 0);

        // Key on the expiry tick wins
        keys(4'b1000);
        ticks(TO - 1);
        tick  = 1'b1;
        inc_p = 1'b1;
        cyc();
        tick  = 1'b0;
        inc_p = 1'b0;
        chk("tk_noabort", set_abort, 0);
        chk("tk_en", set_en, 1);
        chk("tk_hh", set_hh, 8'h10);
        ticks(TO - 1);
        chk("tk_restart", set_en, 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("tk_abort", set_abort, 1);

        // Invalid BCD on entry, then reset mid-edit
        cur_hh = 24'h00_12_2A;
        cur_mm = 24'h00_34_60;
        cur_ss = 24'h00_56_45;
        keys(4'b1000);
        chk("bad_hms", {set_hh, set_mm, set_ss}, 24'h000045);
        keys(4'b0100);
        keys(4'b0010);
        chk("bad_mm1", set_mm, 8'h01);
        rst_n = 1'b0;
        #2;
        chk("mr_en", set_en, 0);
        chk("mr_hms", {set_hh, set_mm, set_ss}, 0);
        chk("mr_blink", blink_sel, 2'b11);
        chk("mr_load", set_load, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mr_noload", set_load, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
